// File: rtl/adc_multi_handoff_pkg.sv
// Shared types and helpers for the multi-channel ADC handoff block.
package adc_multi_handoff_pkg;

  localparam int unsigned DefaultAddrW = 9;
  localparam int unsigned DefaultDataW = 32;

  // Write-port arbiter states.
  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } arb_state_e;

  // Byte address of word idx in channel ch's ring; callers truncate to the port width.
  function automatic logic [31:0] ring_addr(input int unsigned base,
                                            input int unsigned ch,
                                            input int unsigned ring_words,
                                            input int unsigned idx);
    return base + ((ch * ring_words + idx) << 2);
  endfunction

endpackage

// File: rtl/adc_multi_handoff_if.sv
// Memory write port: one request per cycle, held until the memory accepts it.
interface adc_multi_handoff_if
  import adc_multi_handoff_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/adc_multi_handoff_sample_fifo.sv
// Per-channel sample FIFO; a push into a full FIFO is accepted only when it pops that cycle.
module adc_multi_handoff_sample_fifo #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] head,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q;
  logic [PtrW-1:0]     rptr_q;
  logic [PtrW:0]       count_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rptr_q];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  // Sample storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/adc_multi_handoff.sv
// Multi-channel ADC capture: per-channel FIFOs drained round-robin into per-channel
// memory rings through a single write port, with one-shot and wrap capture modes.
module adc_multi_handoff
  import adc_multi_handoff_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RING_WORDS = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    oneshot,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*SAMPLE_W-1:0] ch_data,
  adc_multi_handoff_if.master     wr,
  output logic [NCH-1:0]          ch_done,
  output logic [NCH-1:0]          overflow,
  output logic                    busy
);

  localparam int unsigned ChW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IdxW = (RING_WORDS > 1) ? $clog2(RING_WORDS) : 1;

  logic [NCH-1:0]      fifo_push;
  logic [NCH-1:0]      fifo_pop;
  logic [NCH-1:0]      fifo_full;
  logic [NCH-1:0]      fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head [NCH];

  arb_state_e          state_q;
  logic [ChW-1:0]      rr_q;
  logic [ChW-1:0]      grant_q;
  logic [IdxW-1:0]     idx_q [NCH];
  logic [IdxW-1:0]     idx_d [NCH];
  logic [NCH-1:0]      done_q;
  logic [NCH-1:0]      done_d;
  logic [NCH-1:0]      ovf_q;
  logic [NCH-1:0]      ovf_set;
  logic [NCH-1:0]      elig;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic                hs;
  logic                can_issue;
  logic                issue;
  logic [ChW-1:0]      start;
  logic [ChW-1:0]      pick;
  logic [ADDR_W-1:0]   next_addr;
  logic [DATA_W-1:0]   next_data;

  function automatic logic [ChW-1:0] rr_next(input logic [ChW-1:0] g);
    return (32'(g) == NCH - 1) ? '0 : g + ChW'(1);
  endfunction

  // First set bit of mask at or after from, wrapping modulo NCH.
  function automatic logic [ChW-1:0] rr_pick(input logic [NCH-1:0] mask,
                                             input logic [ChW-1:0] from);
    logic [ChW-1:0] res;
    logic           found;
    int unsigned    c;
    res   = from;
    found = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = 32'(from) + k;
      if (c >= NCH) c = c - NCH;
      if (!found && mask[ChW'(c)]) begin
        found = 1'b1;
        res   = ChW'(c);
      end
    end
    return res;
  endfunction

  // One FIFO per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    adc_multi_handoff_sample_fifo #(
      .SAMPLE_W  (SAMPLE_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (fifo_push[c]),
      .pop  (fifo_pop[c]),
      .wdata(ch_data[c*SAMPLE_W +: SAMPLE_W]),
      .head (fifo_head[c]),
      .full (fifo_full[c]),
      .empty(fifo_empty[c])
    );
  end

  // Ring index and one-shot completion for the write retiring this cycle.
  always_comb begin
    hs     = wr_valid_q && wr.wr_ready;
    idx_d  = idx_q;
    done_d = done_q;
    if (hs) begin
      if (idx_q[grant_q] == IdxW'(RING_WORDS - 1)) begin
        idx_d[grant_q] = '0;
        // oneshot is looked at only on wrap, so a mid-capture change waits for the next wrap.
        if (oneshot) done_d[grant_q] = 1'b1;
      end else begin
        idx_d[grant_q] = idx_q[grant_q] + IdxW'(1);
      end
    end
  end

  // Grant selection, FIFO pops/pushes and overflow detection.
  always_comb begin
    // A channel finishing on this handshake is excluded so it cannot be granted back-to-back.
    elig      = ~fifo_empty & ~done_d;
    start     = hs ? rr_next(grant_q) : rr_q;
    pick      = rr_pick(elig, start);
    can_issue = (state_q == StIdle) || hs;
    issue     = can_issue && (|elig);
    next_addr = ADDR_W'(ring_addr(BASE_ADDR, 32'(pick), RING_WORDS, 32'(idx_d[pick])));
    next_data = DATA_W'(fifo_head[pick]);
    fifo_pop  = '0;
    fifo_push = '0;
    ovf_set   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      // Completed channels drain their leftovers one per cycle without writing them.
      fifo_pop[c]  = (issue && (pick == ChW'(c))) || (done_q[c] && !fifo_empty[c]);
      fifo_push[c] = enable && ch_valid[c] && !done_q[c];
      ovf_set[c]   = fifo_push[c] && fifo_full[c] && !fifo_pop[c];
    end
  end

  // Arbiter FSM with registered write-port outputs and sticky status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      ovf_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int unsigned c = 0; c < NCH; c++) idx_q[c] <= '0;
    end else begin
      idx_q  <= idx_d;
      done_q <= done_d;
      ovf_q  <= ovf_q | ovf_set;
      if (hs) rr_q <= rr_next(grant_q);
      case (state_q)
        StIdle: begin
          if (issue) begin
            grant_q    <= pick;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= next_addr;
            wr_data_q  <= next_data;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (hs) begin
            if (issue) begin
              grant_q    <= pick;
              wr_addr_q  <= next_addr;
              wr_data_q  <= next_data;
            end else begin
              wr_valid_q <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign ch_done     = done_q;
  assign overflow    = ovf_q;
  assign busy        = (|(~fifo_empty)) | wr_valid_q;

endmodule

// File: tb/tb_adc_multi_handoff.sv
// Bench for adc_multi_handoff: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based reference model.
module tb_adc_multi_handoff;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 16;
  localparam int unsigned BASE  = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              oneshot;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*SW-1:0] ch_data;
  logic [NCH-1:0]    ch_done;
  logic [NCH-1:0]    overflow;
  logic              busy;

  always #5 clk = ~clk;

  adc_multi_handoff_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  adc_multi_handoff #(
    .NCH       (NCH),
    .SAMPLE_W  (SW),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .FIFO_DEPTH(DEPTH),
    .RING_WORDS(RW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .oneshot (oneshot),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .wr      (bus),
    .ch_done (ch_done),
    .overflow(overflow),
    .busy    (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SW-1:0]  mq [NCH][$];
  int unsigned    m_idx [NCH];
  logic [NCH-1:0] m_done = '0;
  logic [NCH-1:0] m_ovf  = '0;
  int unsigned    m_rr   = 0;
  int unsigned    m_ch   = 0;
  bit             m_valid = 1'b0;
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_data = '0;

  function automatic logic [AW-1:0] exp_addr(input int unsigned c, input int unsigned i);
    return AW'(BASE + (c * RW + i) * 4);
  endfunction

  function automatic bit m_busy();
    bit b;
    b = m_valid;
    for (int unsigned i = 0; i < NCH; i++) if (mq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] done_old;
    bit             found;
    int unsigned    c;
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        mq[i].delete();
        m_idx[i] = 0;
      end
      m_done = '0; m_ovf = '0; m_rr = 0; m_ch = 0;
      m_valid = 1'b0; m_addr = '0; m_data = '0;
      return;
    end
    done_old = m_done;
    if (m_valid && bus.wr_ready) begin
      m_idx[m_ch] = (m_idx[m_ch] + 1) % RW;
      if (m_idx[m_ch] == 0 && oneshot) m_done[m_ch] = 1'b1;
      m_rr    = (m_ch + 1) % NCH;
      m_valid = 1'b0;
    end
    for (int unsigned i = 0; i < NCH; i++)
      if (done_old[i] && mq[i].size() != 0) void'(mq[i].pop_front());
    if (!m_valid) begin
      found = 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (!found && mq[c].size() != 0 && !m_done[c]) begin
          found   = 1'b1;
          m_ch    = c;
          m_valid = 1'b1;
          m_data  = DW'(mq[c].pop_front());
          m_addr  = exp_addr(c, m_idx[c]);
        end
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (enable && ch_valid[i] && !done_old[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(ch_data[i*SW +: SW]);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  initial for (int unsigned i = 0; i < NCH; i++) m_idx[i] = 0;

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare and write log ----------------
  bit            cmp_en = 1'b0;
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_valid", 32'(bus.wr_valid), 32'(m_valid));
      if (m_valid) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
        chk("wr_data", bus.wr_data, m_data);
      end
      chk("ch_done", 32'(ch_done), 32'(m_done));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_busy()));
    end
    if (!reset && bus.wr_valid && bus.wr_ready) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ch_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic idle(input int n);
    ch_valid = '0;
    repeat (n) tick();
  endtask

  logic [AW-1:0] t2_addr [4];
  int            dens;
  int            rdy;
  int            waited;

  initial begin
    reset = 1'b1; enable = 1'b0; oneshot = 1'b0;
    ch_valid = '0; ch_data = '0; bus.wr_ready = 1'b0;
    t2_addr = '{9'h000, 9'h040, 9'h080, 9'h0C0};
    do_reset();
    cmp_en = 1'b1;

    // Reset state.
    chk("rst_wr_valid", 32'(bus.wr_valid), 32'h0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk("rst_ch_done", 32'(ch_done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single pulse on channel 0: visible one edge after the push edge.
    enable = 1'b1; oneshot = 1'b0; bus.wr_ready = 1'b1;
    ch_valid = 4'b0001; ch_data[15:0] = 16'h1234;
    tick();
    ch_valid = '0;
    chk("t1_valid_at_push", 32'(bus.wr_valid), 32'h0);
    chk("t1_busy_at_push", 32'(busy), 32'h1);
    tick();
    chk("t1_valid", 32'(bus.wr_valid), 32'h1);
    chk("t1_addr", 32'(bus.wr_addr), 32'h000);
    chk("t1_data", bus.wr_data, 32'h0000_1234);
    tick();
    chk("t1_valid_after", 32'(bus.wr_valid), 32'h0);
    chk("t1_busy_after", 32'(busy), 32'h0);

    // All channels at once: back-to-back writes in channel order.
    do_reset();
    ch_valid = '1;
    for (int c = 0; c < NCH; c++) ch_data[c*SW +: SW] = 16'(16'hA0 + c);
    tick();
    ch_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_valid", 32'(bus.wr_valid), 32'h1);
      chk("t2_addr", 32'(bus.wr_addr), 32'(t2_addr[k]));
      chk("t2_data", bus.wr_data, 32'(32'hA0 + k));
    end
    tick();
    chk("t2_valid_after", 32'(bus.wr_valid), 32'h0);

    // Backpressure: one sample held on the port plus DEPTH queued, the rest dropped.
    do_reset();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ch_valid = 4'b0010;
      ch_data[SW +: SW] = 16'(16'h1100 + i);
      tick();
      if (i >= 1) begin
        chk("t3_hold_valid", 32'(bus.wr_valid), 32'h1);
        chk("t3_hold_addr", 32'(bus.wr_addr), 32'h040);
        chk("t3_hold_data", bus.wr_data, 32'h1100);
      end
    end
    ch_valid = '0;
    chk("t3_overflow", 32'(overflow), 32'h2);
    bus.wr_ready = 1'b1;
    idle(8);
    chk("t3_writes", 32'(log_addr.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < log_data.size()) chk("t3_log_data", log_data[k], 32'(32'h1100 + k));
    chk("t3_busy", 32'(busy), 32'h0);

    // One-shot on channel 2: exactly one ring of writes, then done.
    do_reset();
    oneshot = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ch_valid = 4'b0100;
      ch_data[2*SW +: SW] = 16'(16'h2000 + i);
      tick();
    end
    idle(8);
    chk("t4_writes", 32'(log_addr.size()), 32'd16);
    if (log_addr.size() >= 16) begin
      chk("t4_first_addr", 32'(log_addr[0]), 32'h080);
      chk("t4_last_addr", 32'(log_addr[15]), 32'h0BC);
      chk("t4_last_data", log_data[15], 32'h200F);
    end
    chk("t4_done", 32'(ch_done), 32'h4);
    chk("t4_busy", 32'(busy), 32'h0);
    ch_valid = 4'b0100;
    tick();
    idle(5);
    chk("t4_no_more", 32'(log_addr.size()), 32'd16);

    // Continuous on channel 0: 17th write wraps to the ring base.
    do_reset();
    oneshot = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ch_valid = 4'b0001;
      ch_data[15:0] = 16'(16'h3000 + i);
      tick();
    end
    idle(8);
    chk("t5_writes", 32'(log_addr.size()), 32'd17);
    if (log_addr.size() >= 17) begin
      chk("t5_addr15", 32'(log_addr[15]), 32'h03C);
      chk("t5_addr16", 32'(log_addr[16]), 32'h000);
      chk("t5_data16", log_data[16], 32'h3010);
    end
    chk("t5_done", 32'(ch_done), 32'h0);

    // Reset while a write is stalled.
    do_reset();
    bus.wr_ready = 1'b1;
    ch_valid = 4'b1000;
    tick();
    tick();
    idle(4);
    bus.wr_ready = 1'b0;
    ch_valid = 4'b1000;
    ch_data[3*SW +: SW] = 16'h6002;
    tick();
    ch_valid = '0;
    waited = 0;
    while (!bus.wr_valid && waited < 10) begin
      tick();
      waited++;
    end
    chk("t6_pending_valid", 32'(bus.wr_valid), 32'h1);
    chk("t6_pending_addr", 32'(bus.wr_addr), 32'h0C8);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(bus.wr_valid), 32'h0);
    chk("t6_rst_addr", 32'(bus.wr_addr), 32'h0);
    chk("t6_rst_data", bus.wr_data, 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    ch_valid = 4'b1000;
    ch_data[3*SW +: SW] = 16'h5A5A;
    tick();
    ch_valid = '0;
    tick();
    chk("t6_restart_valid", 32'(bus.wr_valid), 32'h1);
    chk("t6_restart_addr", 32'(bus.wr_addr), 32'h0C0);
    chk("t6_restart_data", bus.wr_data, 32'h5A5A);

    // Randomized traffic with occasional resets and mode changes.
    do_reset();
    dens = 30;
    rdy  = 70;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 400 == 0) begin
        dens    = int'($urandom_range(5, 90));
        rdy     = int'($urandom_range(20, 100));
        oneshot = 1'($urandom_range(0, 1));
      end
      enable = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < NCH; c++) ch_valid[c] = (int'($urandom_range(0, 99)) < dens);
      ch_data      = {$urandom(), $urandom()};
      bus.wr_ready = (int'($urandom_range(0, 99)) < rdy);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    idle(20);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
